// File: rtl/key_debounce_pkg.sv
// +----------------------------------------------------------------------+
// | key_debounce_pkg : shared types and helpers for the key debouncer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package key_debounce_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } db_state_t;

    // Widest key vector the popcount helper accepts; callers zero-extend.
    localparam int MAX_KEYS = 64;

    function automatic int unsigned popcount(input logic [MAX_KEYS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_lane.sv
// +----------------------------------------------------------------------+
// | key_debounce_lane : synchroniser + stability FSM for a single key    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module key_debounce_lane
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int             CW         = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    db_state_t     w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;

    // The counter only advances while below the last value, so it never wraps.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            LOW: begin
                if (r_sync2) begin
                    w_state_nxt = CHK_HIGH;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            CHK_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = LOW;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = HIGH;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = CHK_LOW;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            CHK_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = HIGH;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt   = LOW;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: w_state_nxt = LOW;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= key_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// +----------------------------------------------------------------------+
// | key_debounce : N debounced key lanes with press counter and last key |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS          = 8,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CNT_W           = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_KEYS-1:0]         key_raw,
    output logic [N_KEYS-1:0]         key_level,
    output logic [N_KEYS-1:0]         key_press,
    output logic [N_KEYS-1:0]         key_release,
    output logic [CNT_W-1:0]          press_count,
    output logic [$clog2(N_KEYS)-1:0] last_key
);

    localparam int LK_W = $clog2(N_KEYS);

    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;
    logic [LK_W-1:0]   w_first;
    logic [CNT_W-1:0]  w_pop;
    logic [CNT_W-1:0]  r_press_count;
    logic [LK_W-1:0]   r_last_key;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_lane (
            .clock       (clock),
            .reset       (reset),
            .key_raw     (key_raw[gi]),
            .key_level   (w_level[gi]),
            .key_press   (w_press[gi]),
            .key_release (w_release[gi])
        );
    end

    // Descending scan so the lowest set index wins.
    always_comb begin
        w_first = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (w_press[i]) begin
                w_first = LK_W'(i);
            end
        end
    end

    assign w_pop = CNT_W'(popcount(MAX_KEYS'(w_press)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_press_count <= '0;
            r_last_key    <= '0;
        end else begin
            r_press_count <= r_press_count + w_pop;
            if (|w_press) begin
                r_last_key <= w_first;
            end
        end
    end

    assign key_level   = w_level;
    assign key_press   = w_press;
    assign key_release = w_release;
    assign press_count = r_press_count;
    assign last_key    = r_last_key;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// +----------------------------------------------------------------------+
// | tb_key_debounce : directed self-checking bench, DEBOUNCE_CYCLES = 4  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_key_debounce;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] key_raw;
    logic [7:0] key_level;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic [7:0] press_count;
    logic [2:0] last_key;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] raw;
        logic [7:0] level;
        logic [7:0] press;
        logic [7:0] rel;
        logic [7:0] cnt;
        logic [2:0] last;
    } vec_t;

    vec_t tbl[15];

    key_debounce #(
        .N_KEYS          (8),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .press_count (press_count),
        .last_key    (last_key)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] raw, input logic [7:0] level,
                                input logic [7:0] press, input logic [7:0] rel,
                                input logic [7:0] cnt, input logic [2:0] last);
        vec_t v;
        v.raw = raw; v.level = level; v.press = press;
        v.rel = rel; v.cnt = cnt;     v.last = last;
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic pat [8];
        int   n_p;
        int   first_at;
        bit   seen;

        // Clean press/release of key 3, one record per clock, starting idle with count 8.
        tbl[0]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'd8, 3'd0);
        tbl[1]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'd8, 3'd0);
        tbl[2]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'd8, 3'd0);
        tbl[3]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'd8, 3'd0);
        tbl[4]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'd8, 3'd0);
        tbl[5]  = mk(8'h08, 8'h08, 8'h08, 8'h00, 8'd8, 3'd0);
        tbl[6]  = mk(8'h08, 8'h08, 8'h00, 8'h00, 8'd9, 3'd3);
        tbl[7]  = mk(8'h08, 8'h08, 8'h00, 8'h00, 8'd9, 3'd3);
        tbl[8]  = mk(8'h00, 8'h08, 8'h00, 8'h00, 8'd9, 3'd3);
        tbl[9]  = mk(8'h00, 8'h08, 8'h00, 8'h00, 8'd9, 3'd3);
        tbl[10] = mk(8'h00, 8'h08, 8'h00, 8'h00, 8'd9, 3'd3);
        tbl[11] = mk(8'h00, 8'h08, 8'h00, 8'h00, 8'd9, 3'd3);
        tbl[12] = mk(8'h00, 8'h08, 8'h00, 8'h00, 8'd9, 3'd3);
        tbl[13] = mk(8'h00, 8'h00, 8'h00, 8'h08, 8'd9, 3'd3);
        tbl[14] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'd9, 3'd3);

        // Reset with all keys held, then fresh presses on every lane.
        reset   = 1'b0;
        key_raw = 8'hFF;
        step(3);
        chk("rst level",   32'(key_level),   32'h0);
        chk("rst press",   32'(key_press),   32'h0);
        chk("rst release", 32'(key_release), 32'h0);
        chk("rst count",   32'(press_count), 32'h0);
        chk("rst last",    32'(last_key),    32'h0);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk($sformatf("post-rst press c%0d", k), 32'(key_press), 32'h0);
        end
        step(1);
        chk("post-rst press c6", 32'(key_press), 32'hFF);
        chk("post-rst level c6", 32'(key_level), 32'hFF);
        step(1);
        chk("post-rst press c7", 32'(key_press),   32'h0);
        chk("post-rst count",    32'(press_count), 32'd8);
        chk("post-rst last",     32'(last_key),    32'd0);
        key_raw = 8'h00;
        step(6);
        chk("all release", 32'(key_release), 32'hFF);
        chk("all level",   32'(key_level),   32'h00);
        step(4);

        for (int i = 0; i < 15; i++) begin
            key_raw = tbl[i].raw;
            step(1);
            chk($sformatf("vec%0d level", i),   32'(key_level),   32'(tbl[i].level));
            chk($sformatf("vec%0d press", i),   32'(key_press),   32'(tbl[i].press));
            chk($sformatf("vec%0d release", i), 32'(key_release), 32'(tbl[i].rel));
            chk($sformatf("vec%0d count", i),   32'(press_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d last", i),    32'(last_key),    32'(tbl[i].last));
        end
        step(3);

        // Bounce on key 5: runs of three high samples never reach four.
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            key_raw = {2'b00, pat[i], 5'b0};
            step(1);
            chk($sformatf("bounce press c%0d", i), 32'(key_press), 32'h0);
            chk($sformatf("bounce level c%0d", i), 32'(key_level[5]), 32'h0);
        end
        key_raw  = 8'h20;
        n_p      = 0;
        first_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (key_press != 8'h00) begin
                n_p++;
                if (first_at < 0) first_at = k;
            end
        end
        chk("bounce pulse count", 32'(n_p),          32'd1);
        chk("bounce pulse pos",   32'(first_at),     32'd6);
        chk("bounce level held",  32'(key_level),    32'h20);
        chk("bounce count",       32'(press_count),  32'd10);
        chk("bounce last",        32'(last_key),     32'd5);
        key_raw = 8'h00;
        step(10);

        // Simultaneous presses on keys 2, 6 and 7.
        key_raw = 8'hC4;
        seen    = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            step(1);
            if (key_press != 8'h00) seen = 1'b1;
        end
        chk("simul press", 32'(key_press), 32'hC4);
        chk("simul level", 32'(key_level), 32'hC4);
        step(1);
        chk("simul count", 32'(press_count), 32'd13);
        chk("simul last",  32'(last_key),    32'd2);
        key_raw = 8'h00;
        step(10);

        // Counter wrap: 257 presses on key 0 from a cleared count.
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        chk("wrap start count", 32'(press_count), 32'd0);
        for (int i = 0; i < 257; i++) begin
            key_raw = 8'h01;
            step(7);
            key_raw = 8'h00;
            step(7);
        end
        chk("wrap count", 32'(press_count), 32'd1);
        chk("wrap last",  32'(last_key),    32'd0);

        // Reset after two stable high samples on key 1 discards the partial count.
        key_raw = 8'h02;
        step(4);
        reset = 1'b0;
        step(2);
        chk("mid rst level", 32'(key_level),   32'h0);
        chk("mid rst count", 32'(press_count), 32'h0);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk($sformatf("mid rst press c%0d", k), 32'(key_press), 32'h0);
        end
        step(1);
        chk("mid rst press c6", 32'(key_press), 32'h02);
        step(1);
        chk("mid rst count after", 32'(press_count), 32'd1);
        chk("mid rst last",        32'(last_key),    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_debounce.md
# key_debounce

Input-side companion to the LED blink divider: debounces the eight raw board buttons (`key[7:0]`) and converts each clean press into a single-cycle event. Each lane synchronises its key, filters bounce with a per-lane stability counter, and reports the debounced level, press/release pulses, a shared press counter and the index of the most recently pressed key. It sits between the board `key` pins and any lab logic that needs edge events, such as counters, mode selects or LED patterns.

## Interface

Parameters:
- `N_KEYS`, default 8: number of independent key lanes.
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable samples required to accept a level change (about 10 ms at 27 MHz). Must be ≥ 2.
- `CNT_W`, default 8: width of `press_count`.

Ports:
- `clock`, input, 1 bit: the single clock; all state is clocked on its rising edge.
- `reset`, input, 1 bit: synchronous, active-low reset (0 = reset).
- `key_raw`, input, `N_KEYS` bits: asynchronous, bouncy button levels (1 = pressed).
- `key_level`, output, `N_KEYS` bits: debounced level per key.
- `key_press`, output, `N_KEYS` bits: 1-cycle pulse when the debounced level rises.
- `key_release`, output, `N_KEYS` bits: 1-cycle pulse when the debounced level falls.
- `press_count`, output, `CNT_W` bits: running total of accepted presses over all keys; wraps modulo 2^`CNT_W`.
- `last_key`, output, `$clog2(N_KEYS)` bits: index of the most recently pressed key.

## Operation

Per-lane processing:
- Each lane passes `key_raw[i]` through a 2-flop synchroniser to produce `s[i]`.
- Each lane runs a 4-state FSM with states `LOW`, `CHK_HIGH`, `HIGH`, `CHK_LOW` and its own stability counter `cnt`.
- `LOW`: `key_level` = 0. If `s` = 1, go to `CHK_HIGH` with `cnt` = 1.
- `CHK_HIGH`:
  - If `s` = 0, return to `LOW`. This is a glitch; no pulse is produced.
  - If `s` = 1 and `cnt` = `DEBOUNCE_CYCLES`−1, go to `HIGH`, set `key_level` = 1 and pulse `key_press`.
  - Otherwise, increment `cnt`.
- `HIGH` and `CHK_LOW` mirror `LOW` and `CHK_HIGH` with polarity inverted. The accepted transition pulses `key_release` and clears `key_level`.
- `cnt` saturates and is never compared past `DEBOUNCE_CYCLES`−1.

Press counter and last key:
- `press_count` adds the popcount of `key_press` every cycle. Simultaneous presses on k lanes add k in that one cycle. Overflow wraps with no flag.
- `last_key` loads the lowest index set in `key_press` on any cycle with at least one press. Otherwise it holds.

Reset:
- While `reset` = 0, every FSM goes to `LOW` and every register clears: synchroniser flops, `cnt`, `key_level`, `key_press`, `key_release`, `press_count`, `last_key`.
- A key held down through reset is seen as a fresh press after reset deasserts, with full debounce latency. No release pulse is generated for it during reset.
- Reset mid-debounce discards the partial count.

## Timing

- All outputs are registered; nothing is combinational from `key_raw`.
- Latency from a clean `key_raw` edge to the `key_press`/`key_release` pulse is 2 (synchroniser) + `DEBOUNCE_CYCLES` clock cycles.
- `key_level` changes in the same cycle as its pulse.
- Each pulse is exactly 1 cycle wide.
- `press_count` and `last_key` update 1 cycle after the corresponding `key_press` pulse.
- Any bounce shorter than `DEBOUNCE_CYCLES` synchronised samples produces no output change.
- Minimum spacing between two accepted events on one lane is `DEBOUNCE_CYCLES` cycles.
- Lanes are fully independent; events on different lanes may coincide in any cycle.

## Structure

- Package `key_debounce_pkg`:
  - `typedef enum logic [1:0]` `db_state_t` with the values `LOW`, `CHK_HIGH`, `HIGH`, `CHK_LOW`.
  - Function `popcount` over `N_KEYS` bits.
- Sub-module `key_debounce_lane`: synchroniser, FSM, `cnt`, and the level/press/release registers for one key. It takes `DEBOUNCE_CYCLES` as a parameter.
- Top `key_debounce`: generate loop of `N_KEYS` lanes, plus the `press_count` and `last_key` logic.

## Test plan

All scenarios use `DEBOUNCE_CYCLES` = 4 and `CNT_W` = 8.

1. Reset: hold `reset` = 0 for 3 cycles with `key_raw` = 8'hFF. All outputs read 0. After release, `key_press` = 8'hFF exactly 6 cycles later, `press_count` = 8 one cycle after that, and `last_key` = 0.
2. Clean press: raise `key_raw[3]` and hold it. `key_press[3]` pulses for 1 cycle, 6 cycles after the edge, and `key_level[3]` stays 1. Drop it: `key_release[3]` pulses 6 cycles after the edge.
3. Bounce: toggle `key_raw[5]` as 1,1,1,0,1,1,1,0. No pulse appears and `key_level[5]` stays 0. Then hold it at 1: exactly one press pulse follows.
4. Simultaneous presses: raise keys 2, 6 and 7 in the same cycle. Their three pulses coincide, `press_count` increases by 3 in one cycle, and `last_key` = 2.
5. Counter wrap: perform 257 presses on key 0. `press_count` reads 1 at the end.
6. Reset mid-debounce: assert `reset` after 2 stable high samples on key 1, release it, and keep the key held. The press pulse arrives a full 6 cycles after reset release, not earlier.
